// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA transfer sequencer.
package dma_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } dma_xfer_state_e;

    localparam int WORD_BYTES = 4;
    localparam int MAX_RD_LAT = 7;

    // Load value for the WAIT down-counter; latency is clamped to 1..MAX_RD_LAT.
    function automatic logic [2:0] lat_load(input int rd_lat);
        int lat_c;
        if (rd_lat < 1) begin
            lat_c = 1;
        end else if (rd_lat > MAX_RD_LAT) begin
            lat_c = MAX_RD_LAT;
        end else begin
            lat_c = rd_lat;
        end
        return 3'(lat_c - 1);
    endfunction

endpackage

// File: rtl/dma_xfer_ctrl.sv
// Single-channel DMA sequencer: one bus read then one bus write per word.
// Optional stop request enabled by defining DMA_XFER_ABORT_EN.
module dma_xfer_ctrl
    import dma_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
`ifdef DMA_XFER_ABORT_EN
    input  logic              abort,
    output logic              aborted,
`endif
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_done,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata
);

    localparam logic [2:0]        WAIT_LOAD = lat_load(RD_LAT);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(WORD_BYTES);
    localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]  LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};

    dma_xfer_state_e   state_r, state_nxt_s;
    logic              abort_s;
    logic [ADDR_W-1:0] cur_src_r, cur_dst_r, src_nxt_s, dst_nxt_s;
    logic [LEN_W-1:0]  remaining_r, remaining_nxt_s;
    logic [LEN_W-1:0]  words_r, words_nxt_s;
    logic [2:0]        lat_cnt_r, lat_cnt_nxt_s;
    logic [DATA_W-1:0] data_r, data_nxt_s;
    logic              busy_r, done_r, rd_en_r, wr_en_r;
    logic              busy_nxt_s, done_nxt_s, rd_en_nxt_s, wr_en_nxt_s;
    logic [ADDR_W-1:0] addr_r, addr_nxt_s;
    logic [DATA_W-1:0] wdata_r, wdata_nxt_s;

`ifdef DMA_XFER_ABORT_EN
    logic aborted_r;
    assign abort_s = abort;
    assign aborted = aborted_r;

    // Abort pulse: any stop request honoured in an active bus phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            aborted_r <= 1'b0;
        end else begin
            aborted_r <= abort_s && ((state_r == READ) || (state_r == WAIT) || (state_r == WRITE));
        end
    end
`else
    assign abort_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; a stop request in WRITE still lets that write go out.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = (len == LEN_ZERO) ? DONE : READ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            READ: begin
                if (abort_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            WAIT: begin
                if (abort_s) begin
                    state_nxt_s = IDLE;
                end else if (lat_cnt_r == 3'd0) begin
                    state_nxt_s = WRITE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            WRITE: begin
                if (abort_s) begin
                    state_nxt_s = IDLE;
                end else if (remaining_r == LEN_ONE) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = READ;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath and output next values; outputs are derived from the next state
    // so every strobe lines up with the cycle its state is occupied.
    always_comb begin
        src_nxt_s       = cur_src_r;
        dst_nxt_s       = cur_dst_r;
        remaining_nxt_s = remaining_r;
        words_nxt_s     = words_r;
        lat_cnt_nxt_s   = lat_cnt_r;
        data_nxt_s      = data_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    src_nxt_s       = src_addr;
                    dst_nxt_s       = dst_addr;
                    remaining_nxt_s = len;
                    words_nxt_s     = LEN_ZERO;
                end else begin
                    words_nxt_s     = words_r;
                end
            end
            READ:  lat_cnt_nxt_s = WAIT_LOAD;
            WAIT: begin
                if (lat_cnt_r == 3'd0) begin
                    data_nxt_s    = rdata;
                end else begin
                    lat_cnt_nxt_s = lat_cnt_r - 3'd1;
                end
            end
            WRITE: begin
                src_nxt_s       = cur_src_r + ADDR_STEP;
                dst_nxt_s       = cur_dst_r + ADDR_STEP;
                remaining_nxt_s = remaining_r - LEN_ONE;
                words_nxt_s     = words_r + LEN_ONE;
            end
            default: lat_cnt_nxt_s = lat_cnt_r;
        endcase

        rd_en_nxt_s = (state_nxt_s == READ);
        wr_en_nxt_s = (state_nxt_s == WRITE);
        busy_nxt_s  = (state_nxt_s == READ) || (state_nxt_s == WAIT) || (state_nxt_s == WRITE);
        done_nxt_s  = (state_nxt_s == DONE);

        if (state_nxt_s == READ) begin
            addr_nxt_s = src_nxt_s;
        end else if (state_nxt_s == WRITE) begin
            addr_nxt_s = dst_nxt_s;
        end else begin
            addr_nxt_s = addr_r;
        end

        if (state_nxt_s == WRITE) begin
            wdata_nxt_s = data_nxt_s;
        end else begin
            wdata_nxt_s = wdata_r;
        end
    end

    // Datapath and registered bus/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_src_r   <= {ADDR_W{1'b0}};
            cur_dst_r   <= {ADDR_W{1'b0}};
            remaining_r <= LEN_ZERO;
            words_r     <= LEN_ZERO;
            lat_cnt_r   <= 3'd0;
            data_r      <= {DATA_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            rd_en_r     <= 1'b0;
            wr_en_r     <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
        end else begin
            cur_src_r   <= src_nxt_s;
            cur_dst_r   <= dst_nxt_s;
            remaining_r <= remaining_nxt_s;
            words_r     <= words_nxt_s;
            lat_cnt_r   <= lat_cnt_nxt_s;
            data_r      <= data_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            rd_en_r     <= rd_en_nxt_s;
            wr_en_r     <= wr_en_nxt_s;
            addr_r      <= addr_nxt_s;
            wdata_r     <= wdata_nxt_s;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign words_done = words_r;
    assign rd_en      = rd_en_r;
    assign wr_en      = wr_en_r;
    assign addr       = addr_r;
    assign wdata      = wdata_r;

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Bench for dma_xfer_ctrl: per-cycle expected trace built from transfer arithmetic,
// plus literal pins for the directed scenarios. Abort scenario with DMA_XFER_ABORT_EN.
`timescale 1ns/1ps
module tb_dma_xfer_ctrl;

`ifdef DMA_XFER_ABORT_EN
    localparam int L         = 3;
    localparam int PIN_WR1   = 5;
    localparam int PIN_DONE1 = 6;
    localparam int PIN_SPAN3 = 15;
`else
    localparam int L         = 1;
    localparam int PIN_WR1   = 3;
    localparam int PIN_DONE1 = 4;
    localparam int PIN_SPAN3 = 9;
`endif
    localparam int P  = L + 2;
    localparam int NC = 512;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_addr = 32'h0;
    logic [31:0] dst_addr = 32'h0;
    logic [15:0] len = 16'h0;
    logic [31:0] rdata = 32'hBAD0BAD0;
    logic        busy, done, wr_en, rd_en;
    logic [31:0] addr, wdata;
    logic [15:0] words_done;
`ifdef DMA_XFER_ABORT_EN
    logic        abort = 1'b0;
    logic        aborted;
`endif

    dma_xfer_ctrl #(.ADDR_W(32), .DATA_W(32), .LEN_W(16), .RD_LAT(L)) dut (
        .clk(clk), .rst(rst), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
`ifdef DMA_XFER_ABORT_EN
        .abort(abort), .aborted(aborted),
`endif
        .busy(busy), .done(done), .words_done(words_done),
        .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata), .rdata(rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected trace, indexed by cycle number.
    bit          e_rd[NC], e_wr[NC], e_busy[NC], e_done[NC], e_abt[NC], e_zero[NC];
    logic [31:0] e_addr[NC], e_wdata[NC];
    int          e_words[NC];
    bit          h_rd[NC];
    logic [31:0] h_addr[NC];
    logic [31:0] m_addr = 32'h0, m_wdata = 32'h0;
    int          m_words = 0;

    int n_checks = 0;
    int n_err    = 0;

    int          mon_first_rd, mon_done, mon_wr_n, mon_abt;
    bit          mon_busy_seen;
    logic [31:0] mon_rd_q[$], mon_wa_q[$], mon_wd_q[$];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h0000_1000) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'h3C3C};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // Fill the expected trace: word k reads at c0+k*P, writes L+1 cycles later,
    // done at c0+len*P; an abort in cycle ab truncates everything after it.
    task automatic plan(input int c0, input logic [31:0] s, input logic [31:0] d,
                        input int n, input int ab);
        int  fin, last, r, w;
        bit  hit;
        fin  = c0 + n * P;
        hit  = (ab >= c0) && (ab < fin);
        last = hit ? ab : fin - 1;
        e_words[c0] = 0;
        for (int k = 0; k < n; k++) begin
            r = c0 + k * P;
            w = r + L + 1;
            if (r <= last) begin
                e_rd[r] = 1'b1;
                e_addr[r] = s + 32'(4 * k);
            end
            if (w <= last) begin
                e_wr[w] = 1'b1;
                e_addr[w] = d + 32'(4 * k);
                e_wdata[w] = mem_data(s + 32'(4 * k));
                e_words[w + 1] = k + 1;
            end
        end
        for (int c = c0; c <= last; c++) e_busy[c] = 1'b1;
        if (hit) e_abt[ab + 1] = 1'b1;
        else     e_done[fin] = 1'b1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mon_clear;
        mon_first_rd = -1; mon_done = -1; mon_wr_n = 0; mon_abt = 0; mon_busy_seen = 1'b0;
        mon_rd_q.delete(); mon_wa_q.delete(); mon_wd_q.delete();
    endtask

    // Issue a start pulse in the current cycle; returns that cycle number.
    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input int n,
                            input int ab_rel, output int dcyc);
        dcyc = cyc;
        start = 1'b1; src_addr = s; dst_addr = d; len = 16'(n);
        plan(dcyc + 1, s, d, n, (ab_rel < 0) ? -1 : dcyc + 1 + ab_rel);
        tick;
        start = 1'b0;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick;
    endtask

    // Bus agent: rdata valid exactly L cycles after each rd_en, junk otherwise.
    always @(posedge clk) begin
        #1;
        if (cyc >= L && cyc < NC && h_rd[cyc - L]) rdata = mem_data(h_addr[cyc - L]);
        else rdata = 32'hBAD0BAD0;
    end

    // Per-cycle compare against the expected trace, plus event monitor.
    always @(negedge clk) begin
        if (cyc >= 1 && cyc < NC) begin
            h_rd[cyc]   = rd_en;
            h_addr[cyc] = addr;
            if (e_zero[cyc]) begin m_addr = 32'h0; m_wdata = 32'h0; m_words = 0; end
            if (e_rd[cyc] || e_wr[cyc]) m_addr = e_addr[cyc];
            if (e_wr[cyc]) m_wdata = e_wdata[cyc];
            if (e_words[cyc] >= 0) m_words = e_words[cyc];
            chk("rd_en", 32'(rd_en), 32'(e_rd[cyc]));
            chk("wr_en", 32'(wr_en), 32'(e_wr[cyc]));
            chk("busy",  32'(busy),  32'(e_busy[cyc]));
            chk("done",  32'(done),  32'(e_done[cyc]));
            chk("addr",  addr,  m_addr);
            chk("wdata", wdata, m_wdata);
            chk("words_done", 32'(words_done), 32'(m_words));
`ifdef DMA_XFER_ABORT_EN
            chk("aborted", 32'(aborted), 32'(e_abt[cyc]));
            if (aborted === 1'b1) mon_abt++;
`endif
            if (rd_en === 1'b1) begin
                if (mon_first_rd < 0) mon_first_rd = cyc;
                mon_rd_q.push_back(addr);
            end
            if (wr_en === 1'b1) begin
                mon_wr_n++;
                mon_wa_q.push_back(addr);
                mon_wd_q.push_back(wdata);
            end
            if (done === 1'b1) mon_done = cyc;
            if (busy === 1'b1) mon_busy_seen = 1'b1;
        end
    end

    initial begin
        int d, r;
        for (int c = 0; c < NC; c++) e_words[c] = -1;
        mon_clear();

        // Reset, then idle.
        repeat (3) tick;
        rst = 1'b0;
        repeat (3) tick;
        chk("pin_idle_busy", 32'(busy), 32'h0);
        chk("pin_idle_addr", addr, 32'h0);

        // Single word.
        mon_clear();
        do_start(32'h1000, 32'h2000, 1, -1, d);
        run_to(d + P + 4);
        chk("pin1_first_rd", 32'(mon_first_rd - d), 32'h1);
        chk("pin1_done_at", 32'(mon_done - d), 32'(PIN_DONE1));
        chk("pin1_wr_addr", mon_wa_q[0], 32'h0000_2000);
        chk("pin1_wr_data", mon_wd_q[0], 32'hDEADBEEF);
        chk("pin1_words", 32'(words_done), 32'h1);
        chk("pin1_wr_at", 32'(mon_first_rd + L + 1 - d), 32'(PIN_WR1));

        // Three words with ignored start pulses while busy.
        mon_clear();
        do_start(32'h100, 32'h800, 3, -1, d);
        run_to(d + 3);
        start = 1'b1; src_addr = 32'hAAAA_0000; len = 16'd7;
        tick; start = 1'b0;
        run_to(d + 6);
        start = 1'b1; tick; start = 1'b0;
        run_to(d + 3 * P + 4);
        chk("pin3_span", 32'(mon_done - mon_first_rd), 32'(PIN_SPAN3));
        chk("pin3_writes", 32'(mon_wr_n), 32'h3);
        chk("pin3_rd2", mon_rd_q[2], 32'h0000_0108);
        chk("pin3_wr2", mon_wa_q[2], 32'h0000_0808);
        chk("pin3_words", 32'(words_done), 32'h3);

        // Zero-length transfer.
        mon_clear();
        do_start(32'h500, 32'h600, 0, -1, d);
        run_to(d + 5);
        chk("pin0_done_at", 32'(mon_done - d), 32'h1);
        chk("pin0_busy_seen", 32'(mon_busy_seen), 32'h0);
        chk("pin0_strobes", 32'(mon_wr_n + mon_rd_q.size()), 32'h0);

        // Source address wrap.
        mon_clear();
        do_start(32'hFFFF_FFFC, 32'h3000, 2, -1, d);
        run_to(d + 2 * P + 4);
        chk("pinw_rd0", mon_rd_q[0], 32'hFFFF_FFFC);
        chk("pinw_rd1", mon_rd_q[1], 32'h0000_0000);

        // Reset during the second word's WAIT of a 4-word transfer.
        mon_clear();
        do_start(32'h200, 32'h900, 4, -1, d);
        r = d + 1 + P + 1;
        run_to(r);
        rst = 1'b1;
        for (int c = r + 1; c < NC; c++) begin
            e_rd[c] = 1'b0; e_wr[c] = 1'b0; e_busy[c] = 1'b0;
            e_done[c] = 1'b0; e_abt[c] = 1'b0; e_words[c] = -1;
        end
        e_zero[r + 1] = 1'b1;
        tick;
        rst = 1'b0;
        run_to(r + 4 * P);
        chk("pinr_no_done", 32'(mon_done), 32'hFFFF_FFFF);
        chk("pinr_busy", 32'(busy), 32'h0);

        // Recovery transfer after reset.
        do_start(32'h40, 32'h80, 2, -1, d);
        run_to(d + 2 * P + 4);

`ifdef DMA_XFER_ABORT_EN
        // Abort during the second word's WAIT.
        mon_clear();
        do_start(32'h4000, 32'h5000, 4, P + 2, d);
        run_to(d + 1 + P + 2);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        run_to(d + 4 * P + 6);
        chk("pina_writes", 32'(mon_wr_n), 32'h1);
        chk("pina_aborted", 32'(mon_abt), 32'h1);
        chk("pina_no_done", 32'(mon_done), 32'hFFFF_FFFF);
        chk("pina_words", 32'(words_done), 32'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/dma_xfer_ctrl.md
# dma_xfer_ctrl

Single-channel DMA transfer sequencer that drives the DMA register-style bus (wr_en, rd_en, addr, wdata, rdata) as its sole master. On a start command it copies `len` 32-bit words from a source to a destination address range as one bus read followed by one bus write per word. It sits between the DMA programming registers and the memory/register bus agent.

## Interface
- ADDR_W, 32, address width, byte addressing
- DATA_W, 32, data word width
- LEN_W, 16, width of the word-count field
- RD_LAT, 1, cycles from rd_en to valid rdata; legal range 1..7
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle command pulse; ignored while busy=1
- src_addr  input  ADDR_W  source base byte address, sampled with start
- dst_addr  input  ADDR_W  destination base byte address, sampled with start
- len  input  LEN_W  word count, sampled with start
- abort  input  1  stop request; present only with DMA_XFER_ABORT_EN
- busy  output  1  transfer in progress
- done  output  1  one-cycle completion pulse
- aborted  output  1  one-cycle pulse, only with DMA_XFER_ABORT_EN
- words_done  output  LEN_W  words written in the current or last transfer
- wr_en, rd_en  output  1  bus strobes
- addr  output  ADDR_W  bus address
- wdata  output  DATA_W  bus write data
- rdata  input  DATA_W  bus read data

## Operation
- FSM states: IDLE, READ, WAIT, WRITE, DONE.
- IDLE: on start with len≠0, latch src, dst and len, clear words_done, and go to READ. On start with len=0, go to DONE with no bus activity.
- READ (1 cycle): rd_en=1, addr=cur_src. Go to WAIT.
- WAIT (RD_LAT cycles, counted by a 3-bit down-counter): on the last WAIT cycle, capture rdata into the data register. Go to WRITE.
- WRITE (1 cycle): wr_en=1, addr=cur_dst, wdata=captured data.
  - Update: cur_src+=4, cur_dst+=4, remaining−=1, words_done+=1.
  - Next state: READ if remaining≠0 after the decrement, otherwise DONE.
- DONE (1 cycle): done=1. Go to IDLE.
- Address increments wrap modulo 2^ADDR_W, with no error.
- rd_en and wr_en are never high in the same cycle.
- start in any state other than IDLE is ignored and not queued.

## Timing
- All outputs are registered.
- Reset values: busy=0, done=0, aborted=0, wr_en=0, rd_en=0, addr=0, wdata=0, words_done=0, state=IDLE.
- Reset asserted mid-transfer drops all strobes on the next edge and discards the transfer; no done pulse is issued.
- Cost per word: RD_LAT+2 cycles.
- Start sampled at edge E0:
  - busy=1 from the cycle after E0.
  - First rd_en in the cycle after E0.
  - done asserted len·(RD_LAT+2) cycles after the first rd_en cycle.
- busy is low in the cycle done is high. A new start is accepted in the done cycle's following cycle (IDLE).
- len=0: done is high in the cycle after E0 and busy stays 0.
- addr holds its last value in IDLE; wdata holds its last written value.

## Configuration
- DMA_XFER_ABORT_EN defined:
  - The abort port and aborted output exist.
  - abort sampled high in READ or WAIT: go straight to IDLE, with no write for the in-flight word.
  - abort sampled high in WRITE: the write completes, then go to IDLE.
  - In both cases aborted pulses for one cycle instead of done, and words_done reflects only completed writes.
- DMA_XFER_ABORT_EN undefined: the abort and aborted ports are absent, and every started transfer runs to completion.

## Structure
- Shared package `dma_pkg`:
  - typedef enum `dma_xfer_state_e` {IDLE, READ, WAIT, WRITE, DONE}
  - localparam WORD_BYTES=4
  - localparam MAX_RD_LAT=7
- No sub-module. The FSM, address counters and latency counter are all inline in dma_xfer_ctrl.

## Test plan
- Reset, then idle: all outputs 0. Assert rst during WAIT of a 4-word transfer → strobes 0 on the next edge, no done, busy=0.
- src=0x1000, dst=0x2000, len=1, RD_LAT=1, rdata=0xDEADBEEF:
  - rd_en@0x1000 at cycle 1.
  - wr_en@0x2000 with wdata 0xDEADBEEF at cycle 3.
  - done at cycle 4, words_done=1.
- len=3, src=0x100, dst=0x800:
  - Reads at 0x100, 0x104, 0x108; writes at 0x800, 0x804, 0x808 with matching data.
  - done 9 cycles after the first rd_en; words_done=3.
- len=0 → done in the cycle after start, no strobes, busy never 1. Extra start pulses while busy → ignored, transfer unchanged.
- src=0xFFFFFFFC, len=2 → reads at 0xFFFFFFFC then 0x00000000.
- With DMA_XFER_ABORT_EN, len=4, RD_LAT=3, abort during the second word's WAIT:
  - Exactly 1 write issued.
  - aborted pulses, words_done=1, no done.
